// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_WIDTH data bits, optional even/odd parity,
// one or two stop bits, oversampled by b_tick, with parity/framing flags.
module uart_rx_cfg #(
    parameter int OVS_RATE   = 16,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  b_tick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int TW = $clog2(OVS_RATE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVS_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVS_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic                    rx_meta_q, rx_s_q;
    logic [TW-1:0]           tick_q, tick_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    perr_out_q, perr_out_d;
    logic                    ferr_out_q, ferr_out_d;

    logic mid_start, mid_bit;
    assign mid_start = b_tick && (tick_q == TICK_MID);
    assign mid_bit   = b_tick && (tick_q == TICK_END);

    // Synchroniser resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s_q) state_d = START;
            START:  if (mid_start) state_d = rx_s_q ? IDLE : DATA;
            DATA:   if (mid_bit && bit_q == LAST_BIT)
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (mid_bit) state_d = STOP;
            STOP:   if (mid_bit && bit_q == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_busy    = (state_q != IDLE);
        rx_valid   = valid_q;
        rx_data    = data_q;
        parity_err = perr_out_q;
        frame_err  = ferr_out_q;
    end

    // Datapath next-state; bit_q doubles as the stop-bit counter in STOP
    always_comb begin
        tick_d     = tick_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
            end
            START: begin
                if (b_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        bit_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shreg_d = {rx_s_q, shreg_q[DATA_WIDTH-1:1]};
                        bit_d   = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (b_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        bit_d  = '0;
                        perr_d = (((^shreg_q) ^ rx_s_q) != 1'(PARITY_ODD));
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (b_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        ferr_d = ferr_q | ~rx_s_q;
                        if (bit_q == LAST_STOP) begin
                            bit_d      = '0;
                            data_d     = shreg_q;
                            perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                            ferr_out_d = ferr_q | ~rx_s_q;
                            valid_d    = 1'b1;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                tick_d = '0;
                bit_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

endmodule
